// File: rtl/ps2_mem_arbiter.sv
// Round-robin arbiter sharing the PS/2 scan-code memory port between N_REQ requesters.
// Optional WAIT-state timeout enabled by defining PS2_ARB_TIMEOUT_EN.
module ps2_mem_arbiter #(
  parameter int unsigned N_REQ          = 2,
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [N_REQ-1:0]        i_req,
  input  logic [N_REQ-1:0]        i_wren,
  input  logic [N_REQ*ADDR_W-1:0] i_addr,
  output logic [N_REQ-1:0]        o_ack,
  output logic [N_REQ-1:0]        o_err,
  output logic [DATA_W-1:0]       o_rdata,
  output logic                    o_busy,
  output logic                    o_mem_req,
  output logic [ADDR_W-1:0]       o_mem_addr,
  output logic                    o_mem_wren,
  input  logic [DATA_W-1:0]       i_mem_data,
  input  logic                    i_mem_done
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]        state, state_nxt;
  logic [IDX_W-1:0]  rr_ptr, rr_ptr_nxt;
  logic [IDX_W-1:0]  grant, grant_nxt;
  logic              done_q;
  logic              done_edge;
  logic              timeout_hit;
  logic              pick_vld;
  logic [IDX_W-1:0]  pick_idx;
  logic [ADDR_W-1:0] sel_addr;
  logic              sel_wren;
  logic [N_REQ-1:0]  ack_nxt;
  logic [DATA_W-1:0] rdata_nxt;
  logic              busy_nxt;
  logic              mem_req_nxt;
  logic [ADDR_W-1:0] mem_addr_nxt;
  logic              mem_wren_nxt;

  // done is accepted only on its rising edge, tracked in every state
  assign done_edge = i_mem_done & ~done_q;

  // first requester at or above rr_ptr, wrapping
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (!pick_vld && i_req[IDX_W'((32'(rr_ptr) + k) % N_REQ)]) begin
        pick_vld = 1'b1;
        pick_idx = IDX_W'((32'(rr_ptr) + k) % N_REQ);
      end
    end
  end

  always_comb begin
    sel_addr = '0;
    sel_wren = 1'b0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (pick_idx == IDX_W'(k)) begin
        sel_addr = ADDR_W'(i_addr >> (k * ADDR_W));
        sel_wren = i_wren[IDX_W'(k)];
      end
    end
  end

`ifdef PS2_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt;

  // counts WAIT cycles; held at zero elsewhere so it restarts on each WAIT entry
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wait_cnt <= '0;
    end else if (state != S_WAIT) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  assign timeout_hit = (state == S_WAIT) && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // a done edge in the expiry cycle takes priority, so no error then
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_err <= '0;
    end else if (timeout_hit && !done_edge) begin
      o_err <= N_REQ'(1) << grant;
    end else begin
      o_err <= '0;
    end
  end
`else
  logic [31:0] unused_timeout;

  assign unused_timeout = TIMEOUT_CYCLES;
  assign timeout_hit    = 1'b0;
  assign o_err          = '0;
`endif

  always_comb begin
    state_nxt    = state;
    rr_ptr_nxt   = rr_ptr;
    grant_nxt    = grant;
    ack_nxt      = '0;
    rdata_nxt    = o_rdata;
    mem_req_nxt  = 1'b0;
    mem_addr_nxt = o_mem_addr;
    mem_wren_nxt = o_mem_wren;
    case (state)
      S_IDLE: begin
        if (pick_vld) begin
          state_nxt    = S_ISSUE;
          grant_nxt    = pick_idx;
          mem_req_nxt  = 1'b1;
          mem_addr_nxt = sel_addr;
          mem_wren_nxt = sel_wren;
        end
      end
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT: begin
        if (done_edge) begin
          state_nxt      = S_RESP;
          ack_nxt[grant] = 1'b1;
          rdata_nxt      = i_mem_data;
        end else if (timeout_hit) begin
          state_nxt      = S_RESP;
          ack_nxt[grant] = 1'b1;
          rdata_nxt      = '0;
        end
      end
      S_RESP: begin
        state_nxt  = S_IDLE;
        rr_ptr_nxt = (grant == IDX_W'(N_REQ - 1)) ? '0 : grant + IDX_W'(1);
      end
      default: state_nxt = S_IDLE;
    endcase
    busy_nxt = (state_nxt != S_IDLE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= S_IDLE;
      rr_ptr     <= '0;
      grant      <= '0;
      done_q     <= 1'b0;
      o_ack      <= '0;
      o_rdata    <= '0;
      o_busy     <= 1'b0;
      o_mem_req  <= 1'b0;
      o_mem_addr <= '0;
      o_mem_wren <= 1'b0;
    end else begin
      state      <= state_nxt;
      rr_ptr     <= rr_ptr_nxt;
      grant      <= grant_nxt;
      done_q     <= i_mem_done;
      o_ack      <= ack_nxt;
      o_rdata    <= rdata_nxt;
      o_busy     <= busy_nxt;
      o_mem_req  <= mem_req_nxt;
      o_mem_addr <= mem_addr_nxt;
      o_mem_wren <= mem_wren_nxt;
    end
  end

endmodule

// File: tb/tb_ps2_mem_arbiter.sv
// Scoreboard bench for ps2_mem_arbiter: memory responder pushes expected acks,
// a negedge monitor runs a transaction-level round-robin model and compares.
module tb_ps2_mem_arbiter;

  localparam int N_REQ  = 2;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 8;
  localparam int TMO    = 8;

  typedef struct {
    logic [7:0] data;
    logic       err;
    longint     ack_cyc;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req;
  logic [1:0]  wren;
  logic [63:0] addr;
  logic [1:0]  o_ack;
  logic [1:0]  o_err;
  logic [7:0]  o_rdata;
  logic        o_busy;
  logic        o_mem_req;
  logic [31:0] o_mem_addr;
  logic        o_mem_wren;
  logic [7:0]  mem_data;
  logic        mem_done;

  int          errors = 0;
  int          checks = 0;
  longint      cyc = 0;
  logic [1:0]  ack_prev = 2'b00;

  exp_t        mem_q[$];
  int          grant_q[$];

  int unsigned fix_lat = 0;
  bit          fix_data_en = 0;
  logic [7:0]  fix_data = 8'h00;
  bit          no_done = 0;
  int          stray_cnt = 0;

  ps2_mem_arbiter #(
    .N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_wren(wren), .i_addr(addr),
    .o_ack(o_ack), .o_err(o_err), .o_rdata(o_rdata), .o_busy(o_busy),
    .o_mem_req(o_mem_req), .o_mem_addr(o_mem_addr), .o_mem_wren(o_mem_wren),
    .i_mem_data(mem_data), .i_mem_done(mem_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    ack_prev <= o_ack;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got 0x%0h, want 0x%0h", name, cyc, act, exp);
    end
  endtask

  // memory model: answers each request and records the response it will cause
  initial begin
    int unsigned lat;
    int unsigned hold;
    int          stray_seen;
    logic [7:0]  d;
    exp_t        e;
    stray_seen = 0;
    mem_done   = 1'b0;
    mem_data   = 8'h00;
    forever begin
      @(negedge clk);
      if (stray_cnt != stray_seen) begin
        stray_seen = stray_cnt;
        @(posedge clk); #1 mem_done = 1'b1; mem_data = 8'hEE;
        @(posedge clk); #1 mem_done = 1'b0;
      end else if (rst_n && o_mem_req) begin
        lat  = (fix_lat != 0) ? fix_lat : $urandom_range(1, 4);
        hold = $urandom_range(1, 3);
        d    = fix_data_en ? fix_data : 8'($urandom);
        if (no_done) begin
`ifdef PS2_ARB_TIMEOUT_EN
          e = '{8'h00, 1'b1, cyc + longint'(TMO) + 1};
`else
          e = '{8'h00, 1'b0, -1};
`endif
          mem_q.push_back(e);
        end else begin
          e = '{d, 1'b0, cyc + longint'(lat) + 1};
          mem_q.push_back(e);
          repeat (lat) @(posedge clk);
          #1 mem_done = 1'b1; mem_data = d;
          repeat (hold) @(posedge clk);
          #1 mem_done = 1'b0; mem_data = 8'($urandom);
        end
      end
    end
  end

  // reference model and monitor
  logic [1:0]  req_last = 2'b00;
  logic [1:0]  wren_last = 2'b00;
  logic [63:0] addr_last = '0;
  logic [7:0]  last_rdata = 8'h00;
  logic [1:0]  oh;
  bit          idle_prev = 1;
  bit          rst_prev = 0;
  bit          inflight = 0;
  bit          exp_req;
  int          rr_m = 0;
  int          w;
  int          wa;
  exp_t        ea;

  always @(negedge clk) begin
    if (!rst_n) begin
      check("reset_outputs", 128'({o_ack, o_err, o_rdata, o_busy, o_mem_req, o_mem_addr, o_mem_wren}), 128'(0));
      inflight   = 0;
      rr_m       = 0;
      last_rdata = 8'h00;
      idle_prev  = 1;
      rst_prev   = 0;
      grant_q.delete();
      mem_q.delete();
    end else begin
      exp_req = rst_prev && idle_prev && (req_last != 2'b00);
      if (exp_req || o_mem_req) begin
        check("mem_req", 128'(o_mem_req), 128'(exp_req));
        if (exp_req) begin
          w = -1;
          for (int k = 0; k < N_REQ; k++) begin
            if (w < 0 && bit'(req_last >> ((rr_m + k) % N_REQ))) w = (rr_m + k) % N_REQ;
          end
          check("mem_addr", 128'(o_mem_addr), 128'(32'(addr_last >> (w * ADDR_W))));
          check("mem_wren", 128'(o_mem_wren), 128'(1'(wren_last >> w)));
          grant_q.push_back(w);
          inflight = 1;
        end
      end
      check("busy", 128'(o_busy), 128'(inflight));
      idle_prev = !inflight;
      if (inflight && mem_q.size() > 0 && grant_q.size() > 0 && mem_q[0].ack_cyc == cyc) begin
        ea = mem_q.pop_front();
        wa = grant_q.pop_front();
        oh = 2'b01 << wa;
        check("ack", 128'({o_ack, o_err, o_rdata}), 128'({oh, ea.err ? oh : 2'b00, ea.data}));
        last_rdata = ea.data;
        rr_m       = (wa + 1) % N_REQ;
        inflight   = 0;
      end else begin
        check("idle_hold", 128'({o_ack, o_err, o_rdata}), 128'({4'b0000, last_rdata}));
      end
      rst_prev = 1;
    end
    req_last  = req;
    wren_last = wren;
    addr_last = addr;
  end

  // requesters: hold until acked (unless told to keep holding), optional random raises
  task automatic run_cycles(input int n, input bit hold, input bit rnd);
    logic [1:0] m;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      for (int k = 0; k < N_REQ; k++) begin
        m = 2'b01 << k;
        if ((req & m) != 2'b00 && (ack_prev & m) != 2'b00 && !hold) begin
          req = req & ~m;
        end else if (rnd && (req & m) == 2'b00 && $urandom_range(0, 3) == 0) begin
          req  = req | m;
          wren = $urandom_range(0, 1) != 0 ? (wren | m) : (wren & ~m);
          addr = (addr & ~(64'hFFFF_FFFF << (k * ADDR_W))) | (64'($urandom) << (k * ADDR_W));
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 2'b11;
    wren  = 2'b10;
    addr  = {32'h0000_0020, 32'h0000_0010};
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b1;

    // both requesters held: grants must alternate
    run_cycles(60, 1, 0);
    req = 2'b00;
    run_cycles(20, 0, 0);

    // single transaction, fixed latency and data
    fix_lat = 3; fix_data_en = 1; fix_data = 8'h5C;
    wren = 2'b00;
    req  = 2'b01;
    run_cycles(15, 0, 0);

    // requester 1 pulses while requester 0 is in WAIT
    fix_lat = 4; fix_data = 8'h3A;
    req = 2'b01;
    run_cycles(3, 0, 0);
    req = req | 2'b10;
    run_cycles(1, 0, 0);
    req = req & 2'b01;
    run_cycles(12, 0, 0);

    // stray done in IDLE, then a real transaction
    stray_cnt++;
    run_cycles(6, 0, 0);
    fix_lat = 2; fix_data = 8'hA7;
    req = 2'b01;
    run_cycles(12, 0, 0);
    fix_lat = 0; fix_data_en = 0;

    // memory never answers
    no_done = 1;
    req = 2'b01;
    run_cycles(25, 0, 0);
    req = req | 2'b10;
    run_cycles(3, 0, 0);

    // reset mid-transaction, then both request: pointer must restart at 0
    rst_n   = 1'b0;
    no_done = 0;
    req     = 2'b11;
    run_cycles(2, 1, 0);
    rst_n = 1'b1;
    run_cycles(40, 0, 0);

    // random traffic, then drain
    run_cycles(400, 0, 1);
    run_cycles(40, 0, 0);

    check("drain_mem_q", 128'(mem_q.size()), 128'(0));
    check("drain_grant_q", 128'(grant_q.size()), 128'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
